// File: rtl/psum_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// psum_accumulator_pkg
//   Constants shared by the psum accumulate stage and the downstream
//   output/psum-buffer stage: top-level FSM state codes and the psum word
//   geometry (lane count, lane width, fractional bits, buffer address width).
//   The stream-out stage takes its [25:10] slice from PSUM_FRAC/PSUM_LW, so
//   both stages must keep using these definitions.
// -----------------------------------------------------------------------------
package psum_accumulator_pkg;

  typedef logic [2:0] top_state_t;

  localparam top_state_t ST_ACC   = 3'd3;
  localparam top_state_t ST_STORE = 3'd4;

  localparam int PSUM_LANES = 4;
  localparam int PSUM_LW    = 40;
  localparam int PSUM_FRAC  = 10;
  localparam int PSUM_AW    = 8;

endpackage

// File: rtl/psum_lane_add.sv
// -----------------------------------------------------------------------------
// psum_lane_add
//   One psum lane adder: two's complement, result wraps modulo 2^LW
//   (no saturation). Purely combinational.
// Ports
//   a_i    in  LW  previous partial sum for this lane
//   b_i    in  LW  PE contribution for this lane
//   sum_o  out LW  wrapped sum
// -----------------------------------------------------------------------------
module psum_lane_add #(
  parameter int LW = 40
) (
  input  logic signed [LW-1:0] a_i,
  input  logic signed [LW-1:0] b_i,
  output logic signed [LW-1:0] sum_o
);

  // Carry out of the MSB is deliberately discarded.
  function automatic logic signed [LW-1:0] wrap_add(input logic signed [LW-1:0] a,
                                                    input logic signed [LW-1:0] b);
    return a + b;
  endfunction

  assign sum_o = wrap_add(a_i, b_i);

endmodule

// File: rtl/psum_accumulator.sv
// -----------------------------------------------------------------------------
// psum_accumulator
//   Read-modify-write accumulator in front of the psum buffer. Each accepted
//   PE beat (LANES x LW) is added into psum word pe_addr. Three-stage pipeline:
//     S0  issue read (re/ra) for the incoming beat
//     S1  pick old value (read data or forwarded in-flight sum), add per lane
//     S2  write back (we/wa/wd), pulse state_finish_flg on the tile's last beat
//   Address hazards against the two younger writes are resolved by forwarding,
//   so back-to-back beats to the same word accumulate exactly.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   top_level_state   beats are accepted only in ST_ACC
//   pe_valid/addr/data/first/last  PE beat (first: overwrite, last: tile end)
//   re, ra            psum read port (rd returns one cycle after re)
//   rd                psum read data
//   we, wa, wd        psum write port (registered)
//   state_finish_flg  one-cycle pulse when the last beat of a tile is written
// -----------------------------------------------------------------------------
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int LANES = PSUM_LANES,
  parameter int LW    = PSUM_LW,
  parameter int AW    = PSUM_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          top_level_state,
  input  logic                pe_valid,
  input  logic [AW-1:0]       pe_addr,
  input  logic [LANES*LW-1:0] pe_data,
  input  logic                pe_first,
  input  logic                pe_last,
  output logic                re,
  output logic [AW-1:0]       ra,
  input  logic [LANES*LW-1:0] rd,
  output logic                we,
  output logic [AW-1:0]       wa,
  output logic [LANES*LW-1:0] wd,
  output logic                state_finish_flg
);

  localparam int DW = LANES * LW;

  logic          acc_p0;

  logic          vld_p1_q;
  logic [AW-1:0] addr_p1_q;
  logic [DW-1:0] data_p1_q;
  logic          first_p1_q;
  logic          last_p1_q;
  logic [DW-1:0] old_p1;
  logic [DW-1:0] sum_p1;

  logic          vld_p2_q;
  logic [AW-1:0] addr_p2_q;
  logic [DW-1:0] sum_p2_q;
  logic          last_p2_q;

  logic          vld_p3_q;
  logic [AW-1:0] addr_p3_q;
  logic [DW-1:0] sum_p3_q;

  // ---- S0: accept beat, issue psum read ----
  // Reset also blocks acceptance so nothing is read while the pipe is flushed.
  assign acc_p0 = pe_valid && (top_level_state == ST_ACC) && !rst;
  assign re     = acc_p0;
  assign ra     = acc_p0 ? pe_addr : '0;

  // ---- S1: select old value, per-lane wrapping add ----
  // A beat in S2 is writing this cycle, so rd (read last cycle) is stale for
  // its address. A beat that was in S2 last cycle wrote while our read was in
  // flight, and the buffer does not define read-during-write data, so its sum
  // comes from the S3 copy. The younger (S2) match wins.
  always_comb begin
    old_p1 = rd;
    if (first_p1_q) begin
      old_p1 = '0;
    end else if (vld_p2_q && (addr_p2_q == addr_p1_q)) begin
      old_p1 = sum_p2_q;
    end else if (vld_p3_q && (addr_p3_q == addr_p1_q)) begin
      old_p1 = sum_p3_q;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    psum_lane_add #(.LW(LW)) u_add (
      .a_i  (old_p1[i*LW +: LW]),
      .b_i  (data_p1_q[i*LW +: LW]),
      .sum_o(sum_p1[i*LW +: LW])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      addr_p1_q  <= '0;
      data_p1_q  <= '0;
      first_p1_q <= 1'b0;
      last_p1_q  <= 1'b0;
      vld_p2_q   <= 1'b0;
      addr_p2_q  <= '0;
      sum_p2_q   <= '0;
      last_p2_q  <= 1'b0;
      vld_p3_q   <= 1'b0;
      addr_p3_q  <= '0;
      sum_p3_q   <= '0;
    end else begin
      vld_p1_q   <= acc_p0;
      addr_p1_q  <= pe_addr;
      data_p1_q  <= pe_data;
      first_p1_q <= pe_first;
      last_p1_q  <= pe_last;

      // ---- S2: write-back registers ----
      // Loaded only for a valid beat so wa/wd hold between writes.
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        addr_p2_q <= addr_p1_q;
        sum_p2_q  <= sum_p1;
        last_p2_q <= last_p1_q;
      end

      // ---- S3: copy of the word written last cycle, forwarding only ----
      vld_p3_q  <= vld_p2_q;
      addr_p3_q <= addr_p2_q;
      sum_p3_q  <= sum_p2_q;
    end
  end

  assign we               = vld_p2_q;
  assign wa               = addr_p2_q;
  assign wd               = sum_p2_q;
  assign state_finish_flg = vld_p2_q && last_p2_q;

endmodule

// File: tb/tb_psum_accumulator.sv
module tb_psum_accumulator;

  localparam int LANES = 4;
  localparam int LW    = 40;
  localparam int AW    = 8;
  localparam int DW    = LANES * LW;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    top_level_state;
  logic          pe_valid;
  logic [AW-1:0] pe_addr;
  logic [DW-1:0] pe_data;
  logic          pe_first;
  logic          pe_last;
  logic          re;
  logic [AW-1:0] ra;
  logic [DW-1:0] rd;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic          state_finish_flg;

  always #5 clk = ~clk;

  psum_accumulator #(.LANES(LANES), .LW(LW), .AW(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .top_level_state (top_level_state),
    .pe_valid        (pe_valid),
    .pe_addr         (pe_addr),
    .pe_data         (pe_data),
    .pe_first        (pe_first),
    .pe_last         (pe_last),
    .re              (re),
    .ra              (ra),
    .rd              (rd),
    .we              (we),
    .wa              (wa),
    .wd              (wd),
    .state_finish_flg(state_finish_flg)
  );

  int total = 0;
  int bad   = 0;
  int now   = 0;

  // mem: the psum buffer as seen by the DUT; ref_mem: expected buffer contents
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] pending_rd;
  logic [AW-1:0] hold_wa;
  logic [DW-1:0] hold_wd;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          first;
    logic          last;
  } beat_t;
  beat_t inflight[$];

  typedef struct {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } wr_t;
  wr_t wlog[$];
  int  flog[$];

  typedef struct {
    logic [AW-1:0] addr;
    logic          first;
    logic          last;
    logic [DW-1:0] old;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl[4];

  function automatic logic [DW-1:0] rnd160();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] pack4(input logic [LW-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [DW-1:0] lane_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic [LW-1:0] t;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      t = a[i*LW +: LW] + b[i*LW +: LW];
      r[i*LW +: LW] = t;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, now, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  // One clock cycle: inputs are already set (just after negedge). Outputs are
  // sampled mid-low-phase, checked against the reference, then the buffer
  // model responds to the DUT's read/write port.
  task automatic cyc();
    logic          exp_re;
    logic [AW-1:0] exp_ra;
    logic          exp_we;
    logic [DW-1:0] exp_wd;
    beat_t         b;
    rd = pending_rd;
    #2;
    exp_re = pe_valid && (top_level_state == 3'd3) && !rst;
    exp_ra = exp_re ? pe_addr : '0;
    check("re", DW'(re), DW'(exp_re));
    check("ra", DW'(ra), DW'(exp_ra));
    exp_we = (inflight.size() > 0) && (inflight[0].cyc == now);
    check("we", DW'(we), DW'(exp_we));
    if (exp_we) begin
      b      = inflight.pop_front();
      exp_wd = lane_sum(b.first ? '0 : ref_mem[b.addr], b.data);
      ref_mem[b.addr] = exp_wd;
      check("wa", DW'(wa), DW'(b.addr));
      check("wd", wd, exp_wd);
      check("flg", DW'(state_finish_flg), DW'(b.last));
      hold_wa = b.addr;
      hold_wd = exp_wd;
    end else begin
      check("wa_hold", DW'(wa), DW'(hold_wa));
      check("wd_hold", wd, hold_wd);
      check("flg_idle", DW'(state_finish_flg), DW'(1'b0));
    end
    if (we) wlog.push_back('{wa, wd});
    if (state_finish_flg) flog.push_back(now);
    if (rst) begin
      inflight.delete();
      hold_wa = '0;
      hold_wd = '0;
    end else if (exp_re) begin
      inflight.push_back('{now + 2, pe_addr, pe_data, pe_first, pe_last});
    end
    // Buffer model: read-during-write to the same word returns garbage.
    pending_rd = rnd160();
    if (re) pending_rd = (we && (wa == ra)) ? rnd160() : mem[ra];
    if (we) mem[wa] = wd;
    @(negedge clk);
    now++;
  endtask

  task automatic beat(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic f, input logic l);
    top_level_state = 3'd3;
    pe_valid = 1'b1;
    pe_addr  = a;
    pe_data  = d;
    pe_first = f;
    pe_last  = l;
    cyc();
  endtask

  task automatic idle(input int n);
    top_level_state = 3'd3;
    pe_valid = 1'b0;
    pe_first = 1'b0;
    pe_last  = 1'b0;
    repeat (n) cyc();
  endtask

  initial begin
    int t0;
    logic [DW-1:0] ones;
    ones = pack4(40'd1, 40'd1, 40'd1, 40'd1);

    tbl[0] = '{8'd5, 1'b1, 1'b0,
               pack4(40'h123, 40'h456, 40'h789, 40'hABC),
               pack4(40'd1, 40'd2, 40'd3, 40'd4),
               pack4(40'd1, 40'd2, 40'd3, 40'd4)};
    tbl[1] = '{8'd7, 1'b0, 1'b0,
               pack4(40'd10, 40'd10, 40'd10, 40'd10),
               pack4(40'd1, 40'd2, 40'd3, 40'd4),
               pack4(40'd11, 40'd12, 40'd13, 40'd14)};
    tbl[2] = '{8'd12, 1'b0, 1'b0,
               pack4(40'hFF_FFFF_FFFF, 40'h7F_FFFF_FFFF, 40'd5, 40'h80_0000_0000),
               pack4(40'd1, 40'd1, 40'd0, 40'd0),
               pack4(40'd0, 40'h80_0000_0000, 40'd5, 40'h80_0000_0000)};
    tbl[3] = '{8'd200, 1'b0, 1'b1,
               pack4(40'hFF_FFFF_FFFD, 40'h400, 40'd0, 40'd0),
               pack4(40'h400, 40'hFF_FFFF_F800, 40'd0, 40'h7F_FFFF_FFFF),
               pack4(40'h3FD, 40'hFF_FFFF_FC00, 40'd0, 40'h7F_FFFF_FFFF)};

    rst = 1'b1;
    top_level_state = 3'd0;
    pe_valid = 1'b0;
    pe_addr  = '0;
    pe_data  = '0;
    pe_first = 1'b0;
    pe_last  = 1'b0;
    rd       = '0;
    pending_rd = '0;
    hold_wa  = '0;
    hold_wd  = '0;
    for (int i = 0; i < 256; i++) preload(AW'(i), rnd160());
    repeat (2) @(negedge clk);

    // reset state
    cyc();
    cyc();
    rst = 1'b0;
    idle(2);

    // table-driven single beats
    for (int i = 0; i < 4; i++) begin
      preload(tbl[i].addr, tbl[i].old);
      wlog.delete();
      flog.delete();
      beat(tbl[i].addr, tbl[i].data, tbl[i].first, tbl[i].last);
      idle(3);
      check("tbl_nwr", DW'(wlog.size()), DW'(1));
      if (wlog.size() > 0) begin
        check("tbl_wa", DW'(wlog[0].wa), DW'(tbl[i].addr));
        check("tbl_wd", wlog[0].wd, tbl[i].exp);
      end
      check("tbl_nflg", DW'(flog.size()), DW'(tbl[i].last));
    end

    // back-to-back same address (S2 forwarding)
    preload(8'd9, rnd160());
    wlog.delete();
    beat(8'd9, ones, 1'b1, 1'b0);
    beat(8'd9, ones, 1'b0, 1'b0);
    beat(8'd9, ones, 1'b0, 1'b0);
    idle(3);
    check("b2b_nwr", DW'(wlog.size()), DW'(3));
    for (int k = 0; k < 3 && k < wlog.size(); k++) begin
      check("b2b_wa", DW'(wlog[k].wa), DW'(9));
      check("b2b_wd", wlog[k].wd,
            pack4(40'(k + 1), 40'(k + 1), 40'(k + 1), 40'(k + 1)));
    end

    // 9, 4, 9 (S3 forwarding across a read-during-write)
    preload(8'd9, pack4(40'd100, 40'd100, 40'd100, 40'd100));
    preload(8'd4, pack4(40'd7, 40'd7, 40'd7, 40'd7));
    wlog.delete();
    beat(8'd9, ones, 1'b0, 1'b0);
    beat(8'd4, pack4(40'd2, 40'd2, 40'd2, 40'd2), 1'b0, 1'b0);
    beat(8'd9, pack4(40'd5, 40'd5, 40'd5, 40'd5), 1'b0, 1'b0);
    idle(3);
    check("s3_nwr", DW'(wlog.size()), DW'(3));
    if (wlog.size() == 3) begin
      check("s3_wd0", wlog[0].wd, pack4(40'd101, 40'd101, 40'd101, 40'd101));
      check("s3_wd1", wlog[1].wd, pack4(40'd9, 40'd9, 40'd9, 40'd9));
      check("s3_wa2", DW'(wlog[2].wa), DW'(9));
      check("s3_wd2", wlog[2].wd, pack4(40'd106, 40'd106, 40'd106, 40'd106));
    end

    // finish pulse exactly two cycles after the last beat
    flog.delete();
    t0 = now;
    beat(8'd20, rnd160(), 1'b1, 1'b1);
    idle(4);
    check("flg_cnt", DW'(flog.size()), DW'(1));
    if (flog.size() > 0) check("flg_cyc", DW'(flog[0]), DW'(t0 + 2));

    // beats outside state 3 are dropped
    wlog.delete();
    top_level_state = 3'd2;
    pe_valid = 1'b1;
    pe_addr  = 8'd30;
    pe_data  = rnd160();
    cyc();
    cyc();
    idle(3);
    check("st2_nwr", DW'(wlog.size()), DW'(0));

    // reset one cycle after a beat cancels its write
    wlog.delete();
    flog.delete();
    beat(8'd40, rnd160(), 1'b1, 1'b1);
    rst = 1'b1;
    pe_valid = 1'b0;
    cyc();
    rst = 1'b0;
    idle(3);
    check("rst_nwr", DW'(wlog.size()), DW'(0));
    check("rst_nflg", DW'(flog.size()), DW'(0));

    // leaving state 3 with a beat in flight: it still completes
    wlog.delete();
    beat(8'd50, rnd160(), 1'b1, 1'b0);
    top_level_state = 3'd4;
    pe_valid = 1'b1;
    pe_addr  = 8'd51;
    cyc();
    pe_valid = 1'b0;
    repeat (3) cyc();
    check("leave_nwr", DW'(wlog.size()), DW'(1));
    if (wlog.size() > 0) check("leave_wa", DW'(wlog[0].wa), DW'(50));

    // randomized traffic on a small address set to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      top_level_state = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
      pe_valid = ($urandom_range(0, 3) != 0);
      pe_addr  = AW'($urandom_range(0, 7));
      pe_data  = rnd160();
      pe_first = ($urandom_range(0, 4) == 0);
      pe_last  = ($urandom_range(0, 7) == 0);
      cyc();
    end
    rst = 1'b0;
    idle(4);
    check("drain", DW'(inflight.size()), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
